// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - parametrised ALU with single-cycle ops and a fixed-latency multi-cycle path
//
// Purpose:
//   Captures opcode and operands on an accepted start. Single-cycle ops
//   complete one cycle after acceptance. mul/sp1/sp2 complete MUL_LAT cycles
//   after acceptance, and sp0 completes MUL_LAT+1 cycles after acceptance.
//   Reserved opcodes complete in one cycle with an error pulse. A start seen
//   while busy is dropped and latches a sticky flag.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   request strobe, accepted when busy=0 and op is not a nop
//   op       in   4-bit opcode
//   A, B     in   WIDTH-bit operands, sampled on acceptance
//   busy     out  a multi-cycle op is in flight
//   done     out  one-cycle completion pulse
//   error    out  one-cycle pulse with done for a reserved opcode
//   result   out  2*WIDTH-bit last completed result, held between done pulses
//   dropped  out  sticky flag, set by start while busy, cleared by reset only

module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3,
  parameter int SHAMT   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [2*WIDTH-1:0] result,
  output logic               dropped
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_done;
  logic             r_error;
  logic [W2-1:0]    r_result;
  logic             r_dropped;

  logic             w_accept;
  logic             w_is_single;
  logic             w_is_multi;
  logic             w_is_rsvd;
  logic             w_last;
  logic             w_done_nxt;
  logic             w_error_nxt;
  logic [W2-1:0]    w_result_nxt;

  // All arithmetic is done at 2*WIDTH so no op can lose carry or shifted-out bits.
  function automatic logic [W2-1:0] calc(input logic [3:0]       f_op,
                                         input logic [WIDTH-1:0] f_a,
                                         input logic [WIDTH-1:0] f_b);
    logic [W2-1:0] ea;
    logic [W2-1:0] eb;
    ea = W2'(f_a);
    eb = W2'(f_b);
    case (f_op)
      4'd1:    calc = ea + eb;
      4'd2:    calc = ea & eb;
      4'd3:    calc = ea ^ eb;
      4'd4:    calc = ea << SHAMT;
      4'd5:    calc = ea >> SHAMT;
      4'd6:    calc = ea * eb;
      4'd7:    calc = ea + (eb << 1);
      4'd8:    calc = ea << 1;
      4'd9:    calc = ea + (ea << 1);
      default: calc = '0;
    endcase
  endfunction

  // busy is a pure decode of the registered state, so it is glitch-free and
  // drops in the same cycle that done rises.
  assign busy    = (r_state == S_MULTI);
  assign done    = r_done;
  assign error   = r_error;
  assign result  = r_result;
  assign dropped = r_dropped;

  assign w_is_single = (op >= 4'd1) && (op <= 4'd5);
  assign w_is_multi  = (op >= 4'd6) && (op <= 4'd9);
  assign w_is_rsvd   = (op >= 4'd10) && (op <= 4'd14);
  assign w_accept    = start && !busy && (op != 4'd0) && (op != 4'd15);

  // r_cnt counts remaining cycles; at 1 the edge that ends this cycle
  // produces done.
  assign w_last = (r_state == S_MULTI) && (r_cnt == 4'd1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_multi) begin
          w_next_state = S_MULTI;
        end
      end
      S_MULTI: begin
        if (w_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_single) begin
          w_done_nxt   = 1'b1;
          w_result_nxt = calc(op, A, B);
        end else if (w_accept && w_is_rsvd) begin
          w_done_nxt  = 1'b1;
          w_error_nxt = 1'b1;
        end
      end
      S_MULTI: begin
        if (w_last) begin
          w_done_nxt   = 1'b1;
          w_result_nxt = calc(r_op, r_a, r_b);
        end
      end
      default: begin
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Operand capture and latency counter. Captured copies free the inputs
  // to change immediately after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (r_state == S_MULTI) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (w_accept && w_is_multi) begin
      r_op  <= op;
      r_a   <= A;
      r_b   <= B;
      // sp0 runs one cycle longer than the other multi-cycle ops.
      r_cnt <= (op == 4'd7) ? 4'(MUL_LAT) : 4'(MUL_LAT - 1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_result  <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
      r_result <= w_result_nxt;
      if (start && busy) begin
        r_dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int ML = 3;
  localparam int SH = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = 4'd0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [2*W-1:0] result;
  logic          dropped;

  int n_checks = 0;
  int n_pass   = 0;

  alu_pipe #(.WIDTH(W), .MUL_LAT(ML), .SHAMT(SH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .result  (result),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the opcode meaning.
  function automatic logic [15:0] model(input int m_op, input int a, input int b);
    int v;
    case (m_op)
      1: v = a + b;
      2: v = a & b;
      3: v = a ^ b;
      4: v = a * (2 ** SH);
      5: v = a / (2 ** SH);
      6: v = a * b;
      7: v = a + 2 * b;
      8: v = 2 * a;
      9: v = 3 * a;
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  function automatic int latency(input int m_op);
    if (m_op == 7) return ML + 1;
    if (m_op >= 6 && m_op <= 9) return ML;
    return 1;
  endfunction

  logic [15:0] model_res;

  initial begin
    vecs[0] = '{4'd1,  8'hFF, 8'h01, 16'h0100, 1'b0};
    vecs[1] = '{4'd2,  8'hF0, 8'h3C, 16'h0030, 1'b0};
    vecs[2] = '{4'd3,  8'hF0, 8'h3C, 16'h00CC, 1'b0};
    vecs[3] = '{4'd4,  8'hFF, 8'h00, 16'h07F8, 1'b0};
    vecs[4] = '{4'd5,  8'hFF, 8'h00, 16'h001F, 1'b0};
    vecs[5] = '{4'd12, 8'h12, 8'h34, 16'h001F, 1'b1};
    vecs[6] = '{4'd1,  8'hFF, 8'hFF, 16'h01FE, 1'b0};
    vecs[7] = '{4'd10, 8'h00, 8'h00, 16'h01FE, 1'b1};
    vecs[8] = '{4'd14, 8'hAA, 8'h55, 16'h01FE, 1'b1};
    vecs[9] = '{4'd4,  8'h01, 8'h00, 16'h0008, 1'b0};

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_result", result, 0);
    check("rst_dropped", dropped, 0);
    tick;
    reset_n = 1'b1;
    tick;

    // Back-to-back single-cycle and reserved vectors
    for (int i = 0; i < 10; i++) begin
      op = vecs[i].op; A = vecs[i].a; B = vecs[i].b; start = 1'b1;
      tick;
      start = 1'b0;
      check($sformatf("vec%0d_done", i), done, 1);
      check($sformatf("vec%0d_error", i), error, vecs[i].err);
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end
    tick;
    check("vec_done_clears", done, 0);
    check("vec_error_clears", error, 0);

    // nops: no done, no error, no state change
    for (int i = 0; i < 2; i++) begin
      op = (i == 0) ? 4'd0 : 4'd15; start = 1'b1;
      tick;
      start = 1'b0;
      check("nop_done", done, 0);
      check("nop_error", error, 0);
      check("nop_busy", busy, 0);
      check("nop_result", result, 16'h0008);
    end

    // mul with operands changed after acceptance
    op = 4'd6; A = 8'hFF; B = 8'hFF; start = 1'b1;
    tick;
    start = 1'b0; A = 8'h00; B = 8'h00;
    check("mul_c1_busy", busy, 1);
    check("mul_c1_done", done, 0);
    tick;
    check("mul_c2_busy", busy, 1);
    check("mul_c2_done", done, 0);
    tick;
    check("mul_c3_done", done, 1);
    check("mul_c3_busy", busy, 0);
    check("mul_c3_result", result, 16'hFE01);
    tick;
    check("mul_c4_done", done, 0);

    // sp0 then sp2 accepted in the sp0 done cycle
    op = 4'd7; A = 8'd5; B = 8'd7; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("sp0_c%0d_busy", c), busy, 1);
      check($sformatf("sp0_c%0d_done", c), done, 0);
      tick;
    end
    check("sp0_c4_done", done, 1);
    check("sp0_c4_busy", busy, 0);
    check("sp0_c4_result", result, 16'h0013);
    op = 4'd9; A = 8'hFF; B = 8'h00; start = 1'b1;
    tick;
    start = 1'b0;
    check("sp2_c5_busy", busy, 1);
    check("sp2_c5_done", done, 0);
    tick;
    check("sp2_c6_busy", busy, 1);
    tick;
    check("sp2_c7_done", done, 1);
    check("sp2_c7_result", result, 16'h02FD);
    check("sp2_c7_dropped", dropped, 0);
    tick;

    // Drop and recovery
    op = 4'd6; A = 8'd3; B = 8'd4; start = 1'b1;
    tick;
    op = 4'd1; A = 8'd9; B = 8'd9;
    tick;
    start = 1'b0;
    check("drop_set", dropped, 1);
    check("drop_busy", busy, 1);
    check("drop_done", done, 0);
    tick;
    check("drop_mul_done", done, 1);
    check("drop_mul_result", result, 16'h000C);
    op = 4'd1; A = 8'd1; B = 8'd2; start = 1'b1;
    tick;
    start = 1'b0;
    check("drop_add_done", done, 1);
    check("drop_add_result", result, 16'h0003);
    check("drop_sticky", dropped, 1);
    tick;

    // Randomised ops against the model, with stray starts while busy
    model_res = 16'h0003;
    for (int n = 0; n < 60; n++) begin
      int r_op_i;
      int a_i;
      int b_i;
      int exp_lat;
      int seen;
      r_op_i = $urandom_range(0, 15);
      a_i = $urandom_range(0, 255);
      b_i = $urandom_range(0, 255);
      op = 4'(r_op_i); A = 8'(a_i); B = 8'(b_i); start = 1'b1;
      tick;
      start = 1'b0;
      if (r_op_i == 0 || r_op_i == 15) begin
        for (int k = 0; k < 3; k++) begin
          check("rnd_nop_done", done, 0);
          tick;
        end
        check("rnd_nop_result", result, model_res);
      end else begin
        exp_lat = latency(r_op_i);
        seen = 1;
        while (!done && seen < 20) begin
          if (seen < exp_lat && $urandom_range(0, 2) == 0) begin
            op = 4'($urandom_range(0, 15)); A = 8'($urandom); B = 8'($urandom);
            start = 1'b1;
            tick;
            start = 1'b0;
          end else begin
            tick;
          end
          seen++;
        end
        if (r_op_i >= 1 && r_op_i <= 9) model_res = model(r_op_i, a_i, b_i);
        check($sformatf("rnd%0d_op%0d_latency", n, r_op_i), seen, exp_lat);
        check($sformatf("rnd%0d_op%0d_result", n, r_op_i), result, model_res);
        check($sformatf("rnd%0d_op%0d_error", n, r_op_i), error, (r_op_i >= 10) ? 1 : 0);
        tick;
        check($sformatf("rnd%0d_single_done", n), done, 0);
      end
    end

    // Reset mid-operation
    op = 4'd6; A = 8'd10; B = 8'd10; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_dropped", dropped, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("arst_hold_done", done, 0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("arst_after_done", done, 0);
      check("arst_after_busy", busy, 0);
    end
    op = 4'd1; A = 8'h10; B = 8'h20; start = 1'b1;
    tick;
    start = 1'b0;
    check("arst_add_done", done, 1);
    check("arst_add_result", result, 16'h0030);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
